// File: rtl/any1_vmem_seq.sv
// any1_vmem_seq: element sequencer for strided and unit-stride vector loads/stores.
// Walks elements 0..vl-1 and skips masked-off ones. Each active element gets one
// request over a valid/ready handshake. The effective address is built up as
// ea = base + stride*step. Accepted-but-unacknowledged requests are capped at MAXOUT.
module any1_vmem_seq #(
  parameter int unsigned MAXVL  = 64,
  parameter int unsigned AW     = 32,
  parameter int unsigned MAXOUT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             is_store_i,
  input  logic [AW-1:0]    base_i,
  input  logic [AW-1:0]    stride_i,
  input  logic [6:0]       vl_i,
  input  logic [MAXVL-1:0] mask_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [5:0]       step_o,
  output logic             req_valid_o,
  input  logic             req_ready_i,
  output logic [AW-1:0]    req_ea_o,
  output logic [5:0]       req_elem_o,
  output logic             req_store_o,
  input  logic             ack_i,
  input  logic             ack_err_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [3:0] MAXOUT_C = 4'(MAXOUT);

  state_e           state_q, state_d;
  logic [5:0]       step_q, step_d;
  logic [AW-1:0]    ea_q, ea_d;
  logic [3:0]       out_cnt_q, out_cnt_d;
  logic             err_q, err_d;
  logic [AW-1:0]    stride_q;
  logic [6:0]       vl_q;
  logic [MAXVL-1:0] mask_q;
  logic             is_store_q;

  logic elem_on;
  logic accept;
  logic ack_v;
  logic last_elem;

  assign elem_on   = mask_q[step_q];
  assign last_elem = ({1'b0, step_q} == (vl_q - 7'd1));
  // A request is offered only in ISSUE. The element must be enabled, there must be
  // room in the outstanding window, and no fault may have been seen yet.
  assign req_valid_o = (state_q == ISSUE) && elem_on && (out_cnt_q < MAXOUT_C) && !err_q;
  assign accept      = req_valid_o && req_ready_i;
  // An ack that arrives with nothing outstanding is spurious and is dropped completely.
  assign ack_v       = ack_i && (out_cnt_q != 4'd0);

  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign err_o       = err_q;
  assign step_o      = step_q;
  assign req_ea_o    = ea_q;
  assign req_elem_o  = step_q;
  assign req_store_o = is_store_q;

  // Next-state logic: element walk, address accumulation, outstanding count, error.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    step_d    = step_q;
    ea_d      = ea_q;
    err_d     = err_q;
    out_cnt_d = out_cnt_q + {3'b000, accept} - {3'b000, ack_v};
    if (ack_v && ack_err_i) err_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          step_d    = 6'd0;
          ea_d      = base_i;
          err_d     = 1'b0;
          out_cnt_d = 4'd0;
          state_d   = (vl_i == 7'd0) ? DRAIN : ISSUE;
        end
      end
      ISSUE: begin
        // Masked-off elements cost one cycle each. Enabled elements move on only when accepted.
        if (!elem_on || accept) begin
          step_d = step_q + 6'd1;
          ea_d   = ea_q + stride_q;
          if (last_elem) state_d = DRAIN;
        end
        // A fault stops issue right away. Any request still offered is withdrawn next cycle.
        if (err_q || (ack_v && ack_err_i)) state_d = DRAIN;
      end
      DRAIN: begin
        if (out_cnt_d == 4'd0) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state registers. Reset is synchronous and aborts any operation in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    if (rst) begin
      state_q   <= IDLE;
      step_q    <= 6'd0;
      ea_q      <= '0;
      out_cnt_q <= 4'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      ea_q      <= ea_d;
      out_cnt_q <= out_cnt_d;
      err_q     <= err_d;
    end
  end

  // The operation descriptor is captured when start is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      stride_q   <= '0;
      vl_q       <= 7'd0;
      mask_q     <= '0;
      is_store_q <= 1'b0;
    end else if (state_q == IDLE && start_i) begin
      stride_q   <= stride_i;
      vl_q       <= vl_i;
      mask_q     <= mask_i;
      is_store_q <= is_store_i;
    end
  end

endmodule

// File: tb/tb_any1_vmem_seq.sv
// Directed bench for any1_vmem_seq.
// Full operations are driven from a vector table. Stall, window-limit, fault,
// zero-length and reset cases are written out by hand.
module tb_any1_vmem_seq;

  logic        clk;
  logic        rst;
  logic        start_i, is_store_i;
  logic [31:0] base_i, stride_i;
  logic [6:0]  vl_i;
  logic [63:0] mask_i;
  logic        busy_o, done_o, err_o;
  logic [5:0]  step_o;
  logic        req_valid_o, req_ready_i;
  logic [31:0] req_ea_o;
  logic [5:0]  req_elem_o;
  logic        req_store_o;
  logic        ack_i, ack_err_i;

  any1_vmem_seq #(.MAXVL(64), .AW(32), .MAXOUT(4)) dut (
    .clk(clk), .rst(rst),
    .start_i(start_i), .is_store_i(is_store_i), .base_i(base_i), .stride_i(stride_i),
    .vl_i(vl_i), .mask_i(mask_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .step_o(step_o),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_ea_o(req_ea_o),
    .req_elem_o(req_elem_o), .req_store_o(req_store_o),
    .ack_i(ack_i), .ack_err_i(ack_err_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]         vl;
    logic [63:0]        mask;
    logic [31:0]        base;
    logic [31:0]        stride;
    logic               store;
    int                 n;
    logic [0:3][31:0]   ea;
    logic [0:3][5:0]    elem;
  } vec_t;

  vec_t vecs [5];

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] log_ea    [16];
  logic [5:0]  log_elem  [16];
  logic        log_store [16];
  int          n_acc;
  int          done_seen;
  logic        auto_ack;
  logic [1:0]  pipe;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    n_acc     = 0;
    done_seen = 0;
    pipe      = 2'b00;
  endtask

  // One clock: log accepts and done from the settled pre-edge values, then advance.
  // With auto_ack set, each accepted request is acknowledged two cycles later.
  task automatic tick();
    logic acc;
    acc = req_valid_o && req_ready_i;
    if (acc && n_acc < 16) begin
      log_ea[n_acc]    = req_ea_o;
      log_elem[n_acc]  = req_elem_o;
      log_store[n_acc] = req_store_o;
    end
    if (acc) n_acc++;
    if (done_o) done_seen++;
    @(posedge clk);
    #1;
    if (auto_ack) begin
      pipe      = {pipe[0], acc};
      ack_i     = pipe[1];
      ack_err_i = 1'b0;
    end
  endtask

  task automatic run_to_done(input string name, input int budget);
    int cyc;
    cyc = 0;
    while (done_seen == 0 && cyc < budget) begin
      tick();
      cyc++;
    end
    check($sformatf("%s done_pulses", name), 64'(done_seen), 64'd1);
  endtask

  task automatic start_op(input logic [6:0] vl, input logic [63:0] mask, input logic [31:0] base,
                          input logic [31:0] stride, input logic store);
    vl_i = vl; mask_i = mask; base_i = base; stride_i = stride; is_store_i = store;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic run_vec(input int k);
    vec_t  v;
    string nm;
    v  = vecs[k];
    nm = $sformatf("vec%0d", k);
    clear_log();
    auto_ack = 1'b1; ack_i = 1'b0; ack_err_i = 1'b0; req_ready_i = 1'b1;
    start_op(v.vl, v.mask, v.base, v.stride, v.store);
    check({nm, " busy_after_start"}, 64'(busy_o), 64'd1);
    run_to_done(nm, 200);
    check({nm, " n_req"}, 64'(n_acc), 64'(v.n));
    for (int i = 0; i < v.n && i < 4; i++) begin
      check($sformatf("%s ea[%0d]", nm, i), 64'(log_ea[i]), 64'(v.ea[i]));
      check($sformatf("%s elem[%0d]", nm, i), 64'(log_elem[i]), 64'(v.elem[i]));
      check($sformatf("%s store[%0d]", nm, i), 64'(log_store[i]), 64'(v.store));
    end
    check({nm, " err"}, 64'(err_o), 64'd0);
    check({nm, " busy_end"}, 64'(busy_o), 64'd0);
    check({nm, " done_end"}, 64'(done_o), 64'd0);
  endtask

  initial begin
    vecs[0] = '{vl: 7'd4, mask: 64'hF, base: 32'h1000, stride: 32'd8, store: 1'b0, n: 4,
                ea: {32'h1000, 32'h1008, 32'h1010, 32'h1018}, elem: {6'd0, 6'd1, 6'd2, 6'd3}};
    vecs[1] = '{vl: 7'd4, mask: 64'hA, base: 32'h2000, stride: 32'd4, store: 1'b0, n: 2,
                ea: {32'h2004, 32'h200C, 32'h0, 32'h0}, elem: {6'd1, 6'd3, 6'd0, 6'd0}};
    vecs[2] = '{vl: 7'd3, mask: 64'h7, base: 32'h4, stride: 32'hFFFF_FFF8, store: 1'b1, n: 3,
                ea: {32'h4, 32'hFFFF_FFFC, 32'hFFFF_FFF4, 32'h0}, elem: {6'd0, 6'd1, 6'd2, 6'd0}};
    vecs[3] = '{vl: 7'd0, mask: 64'hF, base: 32'h7000, stride: 32'd4, store: 1'b0, n: 0,
                ea: {32'h0, 32'h0, 32'h0, 32'h0}, elem: {6'd0, 6'd0, 6'd0, 6'd0}};
    vecs[4] = '{vl: 7'd64, mask: 64'h8000_0000_0000_0001, base: 32'h0, stride: 32'h10, store: 1'b1,
                n: 2, ea: {32'h0, 32'h3F0, 32'h0, 32'h0}, elem: {6'd0, 6'd63, 6'd0, 6'd0}};

    rst = 1'b1; start_i = 1'b0; is_store_i = 1'b1; base_i = 32'hDEAD_BEEF; stride_i = 32'd4;
    vl_i = 7'd4; mask_i = '1; req_ready_i = 1'b1; ack_i = 1'b0; ack_err_i = 1'b0; auto_ack = 1'b0;
    clear_log();
    tick(); tick();
    check("rst busy", 64'(busy_o), 64'd0);
    check("rst done", 64'(done_o), 64'd0);
    check("rst err", 64'(err_o), 64'd0);
    check("rst req_valid", 64'(req_valid_o), 64'd0);
    check("rst req_store", 64'(req_store_o), 64'd0);
    check("rst step", 64'(step_o), 64'd0);
    check("rst req_elem", 64'(req_elem_o), 64'd0);
    check("rst req_ea", 64'(req_ea_o), 64'd0);
    rst = 1'b0;
    tick();

    for (int k = 0; k < 5; k++) run_vec(k);
    auto_ack = 1'b0; ack_i = 1'b0; ack_err_i = 1'b0;

    // Ready held low on element 0: payload and step stay frozen.
    clear_log(); auto_ack = 1'b1; req_ready_i = 1'b0;
    start_op(7'd2, 64'h3, 32'h100, 32'd4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("stall%0d valid", i), 64'(req_valid_o), 64'd1);
      check($sformatf("stall%0d ea", i), 64'(req_ea_o), 64'h100);
      check($sformatf("stall%0d elem", i), 64'(req_elem_o), 64'd0);
      check($sformatf("stall%0d step", i), 64'(step_o), 64'd0);
      tick();
    end
    req_ready_i = 1'b1;
    run_to_done("stall", 100);
    check("stall n_req", 64'(n_acc), 64'd2);
    check("stall ea1", 64'(log_ea[1]), 64'h104);
    auto_ack = 1'b0; ack_i = 1'b0;

    // Outstanding window: 4 accepts, then stall; one ack releases the 5th request.
    clear_log(); req_ready_i = 1'b1;
    start_op(7'd8, 64'hFF, 32'h3000, 32'd4, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    check("win n_req", 64'(n_acc), 64'd4);
    check("win valid_low", 64'(req_valid_o), 64'd0);
    check("win step", 64'(step_o), 64'd4);
    ack_i = 1'b1; tick(); ack_i = 1'b0;
    check("win valid_after_ack", 64'(req_valid_o), 64'd1);
    check("win elem4", 64'(req_elem_o), 64'd4);
    check("win ea4", 64'(req_ea_o), 64'h3010);
    tick();
    check("win n_req5", 64'(n_acc), 64'd5);
    ack_i = 1'b1;
    run_to_done("win", 100);
    ack_i = 1'b0;
    check("win n_req_total", 64'(n_acc), 64'd8);
    check("win ea7", 64'(log_ea[7]), 64'h301C);
    check("win err", 64'(err_o), 64'd0);

    // Fault on the 2nd ack with 4 outstanding: issue stops, remaining acks drain.
    clear_log();
    start_op(7'd8, 64'hFF, 32'h5000, 32'd4, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    ack_i = 1'b1; ack_err_i = 1'b0; tick();
    ack_err_i = 1'b1; tick();
    ack_i = 1'b0; ack_err_i = 1'b0;
    check("fault n_req", 64'(n_acc), 64'd5);
    check("fault err", 64'(err_o), 64'd1);
    check("fault valid", 64'(req_valid_o), 64'd0);
    tick(); tick();
    check("fault valid_hold", 64'(req_valid_o), 64'd0);
    check("fault n_req_hold", 64'(n_acc), 64'd5);
    check("fault no_done_yet", 64'(done_o), 64'd0);
    check("fault busy", 64'(busy_o), 64'd1);
    ack_i = 1'b1; tick(); tick(); tick(); ack_i = 1'b0;
    check("fault done", 64'(done_o), 64'd1);
    check("fault err_at_done", 64'(err_o), 64'd1);
    tick();
    check("fault busy_end", 64'(busy_o), 64'd0);
    check("fault err_sticky", 64'(err_o), 64'd1);

    // Zero-length operation: no requests, done two cycles after start, err cleared.
    clear_log();
    start_op(7'd0, 64'hFF, 32'h6000, 32'd4, 1'b0);
    check("vl0 err_cleared", 64'(err_o), 64'd0);
    check("vl0 busy", 64'(busy_o), 64'd1);
    check("vl0 done_early", 64'(done_o), 64'd0);
    tick();
    check("vl0 done", 64'(done_o), 64'd1);
    tick();
    check("vl0 busy_end", 64'(busy_o), 64'd0);
    check("vl0 n_req", 64'(n_acc), 64'd0);

    // Reset in the middle of ISSUE aborts at once.
    clear_log(); req_ready_i = 1'b0;
    start_op(7'd8, 64'hFF, 32'h8000, 32'd4, 1'b1);
    check("rstmid valid_before", 64'(req_valid_o), 64'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rstmid busy", 64'(busy_o), 64'd0);
    check("rstmid valid", 64'(req_valid_o), 64'd0);
    check("rstmid store", 64'(req_store_o), 64'd0);
    tick();
    check("rstmid idle", 64'(busy_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
